// File: rtl/muldiv_unit.sv
// Iterative multiply/divide sequencer owning HI/LO for the MIPS EX stage.
// Shift-add multiply, restoring divide, one bit per cycle, sign fix-up in FIX.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mf_req,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               is_div_q, is_div_d;
  logic               dbz_pend_q, dbz_pend_d;
  logic               neg_p_q, neg_p_d;
  logic               neg_r_q, neg_r_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v,
                                           input logic neg);
    return neg ? -v : v;
  endfunction

  logic               sgn_op, sa, sb;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  always_comb begin
    sgn_op = ~op[0];
    sa     = sgn_op & src_a[WIDTH-1];
    sb     = sgn_op & src_b[WIDTH-1];

    mul_sum = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q})
                       : {1'b0, acc_q[2*WIDTH-1:WIDTH]};

    // Remainder stays below the divisor, so W+1 bits cover the shifted value.
    rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, opnd_q};

    prod_fix = neg_p_q ? -acc_q : acc_q;
    quot_fix = neg_p_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    a_raw_d    = a_raw_q;
    is_div_d   = is_div_q;
    dbz_pend_d = dbz_pend_q;
    neg_p_d    = neg_p_q;
    neg_r_d    = neg_r_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    dbz_d      = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          is_div_d   = op[1];
          dbz_pend_d = op[1] & (src_b == '0);
          neg_p_d    = sa ^ sb;
          neg_r_d    = sa;
          a_raw_d    = src_a;
          cnt_d      = CW'(WIDTH - 1);
          dbz_d      = 1'b0;
          if (op[1]) begin
            acc_d  = {{WIDTH{1'b0}}, mag(src_a, sa)};
            opnd_d = mag(src_b, sb);
          end else begin
            acc_d  = {{WIDTH{1'b0}}, mag(src_b, sb)};
            opnd_d = mag(src_a, sa);
          end
          if (!op[1])             state_d = MUL;
          else if (src_b == '0)   state_d = FIX;
          else                    state_d = DIV;
        end
      end
      MUL: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIX;
      end
      DIV: begin
        if (!trial[WIDTH]) acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else               acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        if (dbz_pend_q) begin
          hi_d  = a_raw_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      a_raw_q    <= '0;
      is_div_q   <= 1'b0;
      dbz_pend_q <= 1'b0;
      neg_p_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      a_raw_q    <= a_raw_d;
      is_div_q   <= is_div_d;
      dbz_pend_q <= dbz_pend_d;
      neg_p_q    <= neg_p_d;
      neg_r_q    <= neg_r_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign stall       = busy & (mf_req | start);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;

endmodule
